// File: rtl/uart_rx_fifo.sv
// Purpose: oversampled UART receiver with error-tagged receive FIFO and sticky status flags.
// Latency: word_done/push one cycle after the last stop-bit vote; rd_valid one cycle after a push into an empty FIFO.
// Backpressure: rd_ready pops the head; a push into a full FIFO without a same-cycle pop is dropped and flags overrun.
module uart_rx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int CLK_DIV_W   = 16
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          rx_en,
    input  logic                          rx,
    input  logic [CLK_DIV_W-1:0]          clk_div,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic [1:0]                    rd_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          word_done,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          break_det,
    input  logic                          err_clr
);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [OS_W-1:0] OS_A   = OS_W'(OVERSAMPLE/2 - 1);
    localparam logic [OS_W-1:0] OS_B   = OS_W'(OVERSAMPLE/2);
    localparam logic [OS_W-1:0] OS_V   = OS_W'(OVERSAMPLE/2 + 1);
    localparam logic [OS_W-1:0] OS_END = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [AW:0]     FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_HOLD} state_e;

    typedef struct packed {
        logic [1:0]           err;
        logic [DATA_BITS-1:0] dat;
    } word_t;

    state_e               state_q, state_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CLK_DIV_W-1:0] div_lat_q, div_lat_d, div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_tag_q, par_tag_d, frm_tag_q, frm_tag_d, zero_q, zero_d;
    logic                 done_q, done_d, brk_q, brk_d;
    logic                 parity_err_q, parity_err_d, frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d, break_det_q, break_det_d;

    word_t                mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;

    logic  fall, running, tick, mid_a, mid_b, mid_v, bit_end;
    logic  vote, all_zero, final_vote, exp_par;
    logic  push_vld, push_rdy, push, pop, head_vld;
    word_t push_dat, head;

    assign fall       = rx_prev_q && !rx_s2_q;
    assign running    = (state_q != S_IDLE) && (state_q != S_HOLD);
    assign tick       = running && (div_cnt_q == div_lat_q);
    assign mid_a      = tick && (os_cnt_q == OS_A);
    assign mid_b      = tick && (os_cnt_q == OS_B);
    assign mid_v      = tick && (os_cnt_q == OS_V);
    assign bit_end    = tick && (os_cnt_q == OS_END);
    // Third sample is the live synced rx on the vote tick.
    assign vote       = (samp_q[1] & samp_q[0]) | ((samp_q[1] | samp_q[0]) & rx_s2_q);
    assign all_zero   = zero_q && !vote;
    assign final_vote = (state_q == S_STOP) && mid_v && (bit_cnt_q == STOP_LAST);
    assign exp_par    = (^shift_q) ^ (PARITY_MODE == 2);

    always_ff @(posedge clk_in) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (rx_en && fall) state_d = S_START;
            S_START:  if (mid_v && vote) state_d = S_IDLE;
                      else if (bit_end)  state_d = S_DATA;
            S_DATA:   if (bit_end && (bit_cnt_q == DATA_LAST))
                          state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:   if (final_vote) state_d = all_zero ? S_HOLD : S_IDLE;
            S_HOLD:   if (rx_s2_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (!rx_en) state_d = S_IDLE;
    end

    always_comb begin
        div_lat_d = div_lat_q;
        div_cnt_d = '0;
        os_cnt_d  = '0;
        bit_cnt_d = bit_cnt_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        par_tag_d = par_tag_q;
        frm_tag_d = frm_tag_q;
        zero_d    = zero_q;
        if ((state_q == S_IDLE) && (state_d == S_START)) begin
            div_lat_d = clk_div;
            par_tag_d = 1'b0;
            frm_tag_d = 1'b0;
            zero_d    = 1'b1;
        end
        if (running) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            os_cnt_d  = !tick ? os_cnt_q : ((os_cnt_q == OS_END) ? '0 : os_cnt_q + 1'b1);
        end
        if (state_d != state_q) bit_cnt_d = '0;
        else if (bit_end)       bit_cnt_d = bit_cnt_q + 1'b1;
        if (mid_a) samp_d[1] = rx_s2_q;
        if (mid_b) samp_d[0] = rx_s2_q;
        if (mid_v) begin
            case (state_q)
                S_DATA:   shift_d   = {vote, shift_q[DATA_BITS-1:1]};
                S_PARITY: par_tag_d = (vote != exp_par);
                S_STOP:   frm_tag_d = frm_tag_q | !vote;
                default:  ;
            endcase
            if (state_q inside {S_DATA, S_PARITY, S_STOP}) zero_d = all_zero;
        end
        done_d   = final_vote && rx_en;
        brk_d    = done_d && all_zero;
        push_vld = done_q && !brk_q;
        push_dat = '{err: {par_tag_q, frm_tag_q}, dat: shift_q};
        // Set events win over a same-cycle clear.
        parity_err_d = (parity_err_q && !err_clr) || (done_q && par_tag_q);
        frame_err_d  = (frame_err_q  && !err_clr) || (done_q && frm_tag_q);
        break_det_d  = (break_det_q  && !err_clr) || (done_q && brk_q);
        overrun_d    = (overrun_q    && !err_clr) || (push_vld && !push_rdy);
    end

    assign head_vld = (count_q != '0);
    assign push_rdy = (count_q != FULL_CNT) || rd_ready;
    assign push     = push_vld && push_rdy;
    assign pop      = head_vld && rd_ready;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            div_lat_q    <= '0;
            div_cnt_q    <= '0;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            shift_q      <= '0;
            par_tag_q    <= 1'b0;
            frm_tag_q    <= 1'b0;
            zero_q       <= 1'b0;
            done_q       <= 1'b0;
            brk_q        <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            break_det_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            rx_s1_q      <= rx;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            div_lat_q    <= div_lat_d;
            div_cnt_q    <= div_cnt_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_tag_q    <= par_tag_d;
            frm_tag_q    <= frm_tag_d;
            zero_q       <= zero_d;
            done_q       <= done_d;
            brk_q        <= brk_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            break_det_q  <= break_det_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= push_dat;
    end

    assign rd_valid   = head_vld;
    assign rd_data    = head_vld ? head.dat : '0;
    assign rd_err     = head_vld ? head.err : '0;
    assign fifo_count = count_q;
    assign word_done  = done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign break_det  = break_det_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with a buffered receive FIFO, for the peripheral subsystem and for bench-side UART monitoring. It generalises the fixed 8-bit, parity-less bench receiver model with configurable data width, parity mode, stop bits, oversampling and FIFO depth. It also adds per-word error tagging, break detection and sticky status flags. Words are read out through a valid/ready interface.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, ticks per bit (even, >= 8)
FIFO_DEPTH, 8, entries (power of 2, >= 2)
CLK_DIV_W, 16, width of clk_div

Ports:
clk_in  in  1  system clock
reset  in  1  synchronous reset, active-high
rx_en  in  1  receiver enable
rx  in  1  serial input, asynchronous
clk_div  in  CLK_DIV_W  clk_in cycles per oversample tick minus 1
rd_valid  out  1  FIFO head valid
rd_ready  in  1  consumer accepts head
rd_data  out  DATA_BITS  head data
rd_err  out  2  head error tag {parity_err, frame_err}
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
word_done  out  1  one-cycle pulse per completed frame
parity_err  out  1  sticky
frame_err  out  1  sticky
overrun  out  1  sticky
break_det  out  1  sticky
err_clr  in  1  clears all sticky flags

Behaviour:
- Interface: one clock, clk_in. reset is synchronous and active-high.
- Reset values:
  - all outputs 0, FIFO empty.
  - 2-FF rx synchroniser resets to 1.
  - FSM in IDLE.
- Tick generator:
  - Counter runs 0..clk_div and emits a tick when it wraps.
  - It is held at 0 in IDLE.
  - clk_div is sampled on leaving IDLE. Changes during a frame have no effect until the next frame.
- Majority sample: 2-of-3 vote over the synced rx at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit.
- FSM transitions:
  - IDLE -> START when rx_en=1 and the synced rx falls.
  - START: the vote is taken at mid-bit. If the vote is 1 (false start), go to IDLE with nothing recorded. Otherwise go to DATA.
  - DATA: shift DATA_BITS bits, LSB first. Then go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: compare the parity bit against the XOR of the data (even) or its inverse (odd). A mismatch sets the word's parity tag.
  - STOP: check STOP_BITS stop bits. Any stop bit voted 0 sets the frame tag. The frame ends at the mid-sample of the last stop bit.
- Frame completion, on the cycle after the final stop sample:
  - word_done pulses and the word plus tag is pushed.
  - The tag ORs into the sticky parity_err / frame_err flags.
  - FSM returns to IDLE. A new start edge is accepted from the next cycle.
- Break: if all data bits, the parity bit (if present) and the stop bits are 0:
  - break_det=1 and frame_err=1.
  - word_done pulses, but nothing is pushed.
  - FSM waits in IDLE-HOLD until the synced rx=1, then goes to IDLE.
- FIFO:
  - Registered. rd_valid rises the cycle after a push into an empty FIFO.
  - A pop occurs on rd_valid & rd_ready.
  - Push while full without a same-cycle pop: new word dropped, overrun=1.
  - Push while full with a same-cycle pop: both occur, count unchanged, no overrun.
  - Pointers wrap modulo FIFO_DEPTH.
- rx_en=0 mid-frame: FSM aborts to IDLE the next cycle, the partial word is discarded, FIFO contents are kept.
- err_clr: all sticky flags go to 0 next cycle. If a set event occurs in the same cycle, set wins.
- reset mid-frame: all state returns to reset values next cycle.

Test Plan:
1. 8N1, clk_div=3 (64 clks/bit), send 0xA5 -> one word_done pulse; rd_data=0xA5, rd_err=00, fifo_count=1; rd_ready=1 -> count 0.
2. PARITY_MODE=1, send 0x31 with parity bit 0 (correct is 1) -> rd_data=0x31, rd_err=10, parity_err=1; err_clr clears the flag.
3. rx low for 16 clks, then high (shorter than half a bit) -> no word_done, count 0, FSM in IDLE.
4. FIFO_DEPTH=8, send 9 words 0x00..0x08 without reading -> count 8, overrun=1; reads return 0x00..0x07 in order.
5. rx low for 12 bit times -> break_det=1, frame_err=1, count unchanged; a following 0x5A is received after rx returns high.
6. Assert reset during data bit 3 -> all outputs 0 next cycle; a subsequent 0x5A is received correctly with rd_err=00.
